// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the fetch stage
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    kIdle = 2'd0,
    kRun  = 2'd1,
    kHalt = 2'd2
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_TGT1 = 2'b01;
  localparam logic [1:0] SEL_TGT2 = 2'b10;
  localparam logic [1:0] SEL_TGT3 = 2'b11;

  localparam int PC_WIDTH_DFLT = 10;

endpackage

// File: rtl/pc_target_regs.sv
// rtl/pc_target_regs.sv - three writable jump targets plus a hardwired entry 0
module pc_target_regs
  import pc_fetch_pkg::*;
#(
  parameter int          PC_WIDTH   = PC_WIDTH_DFLT,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                i_wr_en,
  input  logic [1:0]          i_wr_sel,
  input  logic [PC_WIDTH-1:0] i_wr_data,
  input  logic [1:0]          i_rd_sel,
  output logic [PC_WIDTH-1:0] o_rd_data
);

  localparam logic [PC_WIDTH-1:0] START_PC = START_ADDR[PC_WIDTH-1:0];

  logic [PC_WIDTH-1:0] r_tgt1;
  logic [PC_WIDTH-1:0] r_tgt2;
  logic [PC_WIDTH-1:0] r_tgt3;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_tgt1 <= START_PC;
      r_tgt2 <= START_PC;
      r_tgt3 <= START_PC;
    end else if (i_wr_en) begin
      case (i_wr_sel)
        SEL_TGT1: r_tgt1 <= i_wr_data;
        SEL_TGT2: r_tgt2 <= i_wr_data;
        SEL_TGT3: r_tgt3 <= i_wr_data;
        default:  ;
      endcase
    end
  end

  // Entry 0 is the program entry point, so an unselected jump restarts the program.
  always_comb begin
    o_rd_data = START_PC;
    case (i_rd_sel)
      SEL_TGT1: o_rd_data = r_tgt1;
      SEL_TGT2: o_rd_data = r_tgt2;
      SEL_TGT3: o_rd_data = r_tgt3;
      default:  o_rd_data = START_PC;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter, jump resolution and start/halt sequencing
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int          PC_WIDTH   = PC_WIDTH_DFLT,
  parameter int unsigned START_ADDR = 0,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Ack,
  input  logic                 JumpEqual,
  input  logic                 JumpNotEqual,
  input  logic                 OffsetEn,
  input  logic [1:0]           PCRegSelect,
  input  logic [7:0]           ImmOut,
  input  logic                 ZeroFlag,
  output logic [PC_WIDTH-1:0]  InstAddr,
  output logic                 Running,
  output logic                 Done,
  output logic [CNT_WIDTH-1:0] InstCount
);

  localparam logic [PC_WIDTH-1:0]  START_PC = START_ADDR[PC_WIDTH-1:0];
  localparam logic [PC_WIDTH-1:0]  PC_ONE   = PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t               r_state;
  state_t               w_state_next;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [PC_WIDTH-1:0]  w_pc_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  logic                w_taken;
  logic                w_tgt_wr;
  logic [PC_WIDTH-1:0] w_tgt_wdata;
  logic [PC_WIDTH-1:0] w_tgt_rdata;

  assign w_taken     = (JumpEqual & ZeroFlag) | (JumpNotEqual & ~ZeroFlag);
  assign w_tgt_wr    = (r_state == kRun) & ~Ack & ~JumpEqual & ~JumpNotEqual
                     & (PCRegSelect != SEL_NONE);
  assign w_tgt_wdata = OffsetEn ? (r_pc + PC_WIDTH'(ImmOut)) : r_pc;

  pc_target_regs #(
    .PC_WIDTH   (PC_WIDTH),
    .START_ADDR (START_ADDR)
  ) u_tgt (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_wr_en   (w_tgt_wr),
    .i_wr_sel  (PCRegSelect),
    .i_wr_data (w_tgt_wdata),
    .i_rd_sel  (PCRegSelect),
    .o_rd_data (w_tgt_rdata)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= kIdle;
      r_pc    <= START_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Ack wins over any jump in the same cycle: the halting instruction does not retire.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    case (r_state)
      kIdle, kHalt: begin
        if (Start) begin
          w_state_next = kRun;
          w_pc_next    = START_PC;
          w_cnt_next   = '0;
        end
      end
      kRun: begin
        if (Ack) begin
          w_state_next = kHalt;
        end else begin
          w_pc_next = w_taken ? w_tgt_rdata : (r_pc + PC_ONE);
          if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        w_state_next = kIdle;
      end
    endcase
  end

  assign InstAddr  = r_pc;
  assign Running   = (r_state == kRun);
  assign Done      = (r_state == kHalt);
  assign InstCount = r_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - randomized and directed checks of pc_fetch against a behavioural model
module tb_pc_fetch;

  localparam int PCW  = 10;
  localparam int CW   = 6;
  localparam int PMOD = 1 << PCW;
  localparam int CMAX = (1 << CW) - 1;

  logic           Clk;
  logic           Reset;
  logic           Start;
  logic           Ack;
  logic           JumpEqual;
  logic           JumpNotEqual;
  logic           OffsetEn;
  logic [1:0]     PCRegSelect;
  logic [7:0]     ImmOut;
  logic           ZeroFlag;
  logic [PCW-1:0] InstAddr;
  logic           Running;
  logic           Done;
  logic [CW-1:0]  InstCount;

  pc_fetch #(.PC_WIDTH(PCW), .START_ADDR(0), .CNT_WIDTH(CW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .Ack          (Ack),
    .JumpEqual    (JumpEqual),
    .JumpNotEqual (JumpNotEqual),
    .OffsetEn     (OffsetEn),
    .PCRegSelect  (PCRegSelect),
    .ImmOut       (ImmOut),
    .ZeroFlag     (ZeroFlag),
    .InstAddr     (InstAddr),
    .Running      (Running),
    .Done         (Done),
    .InstCount    (InstCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model: mode 0=idle 1=run 2=halt
  int m_mode;
  int m_pc;
  int m_cnt;
  int m_tgt [4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) m_tgt[i] = 0;
  endtask

  task automatic model_step();
    bit taken;
    int sel;
    sel = int'(PCRegSelect);
    if (m_mode == 0 || m_mode == 2) begin
      if (Start) begin
        m_mode = 1;
        m_pc   = 0;
        m_cnt  = 0;
      end
    end else if (Ack) begin
      m_mode = 2;
    end else begin
      taken = (JumpEqual && ZeroFlag) || (JumpNotEqual && !ZeroFlag);
      if (taken) begin
        m_pc = m_tgt[sel];
      end else begin
        if (sel != 0 && !JumpEqual && !JumpNotEqual)
          m_tgt[sel] = OffsetEn ? (m_pc + int'(ImmOut)) % PMOD : m_pc;
        m_pc = (m_pc + 1) % PMOD;
      end
      if (m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic clear_in();
    Start = 0; Ack = 0; JumpEqual = 0; JumpNotEqual = 0;
    OffsetEn = 0; PCRegSelect = 2'b00; ImmOut = 8'h00; ZeroFlag = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!Reset) model_reset();
    else model_step();
    #2;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("InstAddr",  int'(InstAddr),  m_pc);
      check("Running",   int'(Running),   (m_mode == 1) ? 1 : 0);
      check("Done",      int'(Done),      (m_mode == 2) ? 1 : 0);
      check("InstCount", int'(InstCount), m_cnt);
    end
  end

  int sv_cnt;

  initial begin
    Reset = 0;
    clear_in();
    model_reset();
    tick(); tick();
    check("rst_addr", int'(InstAddr), 0);
    check("rst_run", int'(Running), 0);
    check("rst_done", int'(Done), 0);
    check("rst_cnt", int'(InstCount), 0);
    chk_en = 1'b1;
    Reset = 1;
    tick();
    check("idle_hold", int'(InstAddr), 0);

    Start = 1; tick(); Start = 0;
    check("start_addr", int'(InstAddr), 0);
    check("start_run", int'(Running), 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("step_addr", int'(InstAddr), i);
    end
    tick();
    check("cnt4", int'(InstCount), 4);
    tick();
    check("pc5", int'(InstAddr), 5);

    PCRegSelect = 2'b10; OffsetEn = 1; ImmOut = 8'h12;
    tick(); clear_in();
    check("tgtwr_pc", int'(InstAddr), 6);
    check("model_tgt2", m_tgt[2], 'h17);
    JumpNotEqual = 1; ZeroFlag = 0; PCRegSelect = 2'b10;
    tick(); clear_in();
    check("jne_taken", int'(InstAddr), 'h17);

    JumpEqual = 1; ZeroFlag = 1; PCRegSelect = 2'b00;
    tick(); clear_in();
    check("jmp_sel0", int'(InstAddr), 0);
    repeat (9) tick();
    check("pc9", int'(InstAddr), 9);
    JumpEqual = 1; ZeroFlag = 0;
    tick(); clear_in();
    check("je_not_taken", int'(InstAddr), 10);
    JumpEqual = 1; ZeroFlag = 1;
    tick(); clear_in();
    check("je_taken0", int'(InstAddr), 0);

    // chain offset writes and jumps to climb to 0x3FC
    repeat (4) begin
      PCRegSelect = 2'b11; OffsetEn = 1; ImmOut = 8'hFF;
      tick(); clear_in();
      JumpEqual = 1; ZeroFlag = 1; PCRegSelect = 2'b11;
      tick(); clear_in();
    end
    check("pc3fc", int'(InstAddr), 'h3FC);
    repeat (3) tick();
    check("pc3ff", int'(InstAddr), 'h3FF);
    tick();
    check("wrap", int'(InstAddr), 0);

    sv_cnt = m_cnt;
    Ack = 1; JumpEqual = 1; ZeroFlag = 1; PCRegSelect = 2'b10;
    tick(); clear_in();
    check("ack_done", int'(Done), 1);
    check("ack_pc", int'(InstAddr), 0);
    check("ack_cnt", int'(InstCount), sv_cnt);
    repeat (3) begin
      JumpEqual = 1'($urandom); ZeroFlag = 1'($urandom); PCRegSelect = 2'($urandom);
      OffsetEn = 1'($urandom); ImmOut = 8'($urandom);
      tick();
    end
    clear_in();
    check("halt_frozen", int'(InstAddr), 0);

    Start = 1; tick();
    check("restart_pc", int'(InstAddr), 0);
    check("restart_cnt", int'(InstCount), 0);
    tick(); Start = 0;
    check("long_start", int'(InstAddr), 1);
    JumpEqual = 1; ZeroFlag = 1; PCRegSelect = 2'b10;
    tick(); clear_in();
    check("tgt2_kept", int'(InstAddr), 'h17);

    repeat (70) tick();
    check("cnt_sat", int'(InstCount), CMAX);

    Ack = 1; tick(); clear_in();
    Start = 1; tick(); Start = 0;
    repeat (7) tick();
    check("pc7", int'(InstAddr), 7);
    Reset = 0;
    #1;
    check("async_addr", int'(InstAddr), 0);
    check("async_run", int'(Running), 0);
    check("async_done", int'(Done), 0);
    check("async_cnt", int'(InstCount), 0);
    model_reset();
    tick();
    Reset = 1;
    tick();

    repeat (3000) begin
      Start        = ($urandom_range(0, 19) == 0);
      Ack          = ($urandom_range(0, 29) == 0);
      JumpEqual    = ($urandom_range(0, 5) == 0);
      JumpNotEqual = ($urandom_range(0, 5) == 0);
      OffsetEn     = 1'($urandom);
      PCRegSelect  = 2'($urandom);
      ImmOut       = 8'($urandom);
      ZeroFlag     = 1'($urandom);
      tick();
    end
    clear_in();
    tick();
    @(negedge Clk);
    #1;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction decoder. It drives the instruction-ROM address, holds the three programmable jump-target registers selected by the decoder's `PCRegSelect`, and resolves conditional jumps against the ALU zero flag. It also runs the start/halt handshake that brackets each program run.

## Interface
Parameters:
- `PC_WIDTH`, 10: program-counter / instruction-ROM address width.
- `START_ADDR`, 0: PC value loaded on reset and on every `Start`.
- `CNT_WIDTH`, 16: width of the retired-instruction counter.

Ports:
- `Clk` input 1: single clock; all state updates on its rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `Start` input 1: one-cycle pulse that begins a program run.
- `Ack` input 1: decoder halt indication for the current instruction.
- `JumpEqual` input 1: current instruction is jump-if-zero.
- `JumpNotEqual` input 1: current instruction is jump-if-not-zero.
- `OffsetEn` input 1: target-register write uses PC + `ImmOut`.
- `PCRegSelect` input 2: jump-target register index; 00 means none.
- `ImmOut` input 8: decoder immediate, treated as an unsigned offset.
- `ZeroFlag` input 1: registered ALU zero flag from the prior instruction.
- `InstAddr` output PC_WIDTH: instruction-ROM address, equal to the PC register.
- `Running` output 1: high while in RUN; gates `RegWrEn`/`MemWrEn` downstream.
- `Done` output 1: high while in HALT.
- `InstCount` output CNT_WIDTH: number of instructions retired in the current run.

## Operation
- FSM states: IDLE, RUN, HALT. Reset state is IDLE.
- Reset values: PC = `START_ADDR`; `TgtReg[1..3]` = `START_ADDR`; `InstCount` = 0; `Running` = 0; `Done` = 0.
- IDLE, on `Start`: go to RUN and load PC = `START_ADDR`. All other inputs are ignored in IDLE.
- RUN, per cycle, evaluated in priority order:
  1. If `Ack`=1: go to HALT. PC, target registers and `InstCount` do not change.
  2. If a jump is taken: PC = `TgtReg[PCRegSelect]`. A jump is taken when (`JumpEqual` & `ZeroFlag`) | (`JumpNotEqual` & ~`ZeroFlag`).
  3. Otherwise PC = PC + 1, wrapping modulo 2^PC_WIDTH.
- Target-register write happens in RUN when `PCRegSelect`≠00, `JumpEqual`=0, `JumpNotEqual`=0 and `Ack`=0:
  - `TgtReg[sel]` = PC when `OffsetEn`=0.
  - `TgtReg[sel]` = PC + zero-extended `ImmOut`, truncated to PC_WIDTH, when `OffsetEn`=1.
  - PC still advances by 1 on that cycle.
- `TgtReg[0]` is hardwired to `START_ADDR` and is never written. A jump with sel=00 that is taken goes to `START_ADDR`.
- A not-taken jump behaves as PC + 1. It never writes a target register.
- `JumpEqual` and `JumpNotEqual` both high in the same cycle is illegal. Resolution is still the OR of the two conditions.
- `InstCount` increments by 1 on every RUN cycle without `Ack`. It saturates at all-ones.
- HALT: all state is frozen.
  - On `Start`: go to RUN with PC = `START_ADDR` and `InstCount` = 0. Target registers are retained.
- `Start` is ignored while in RUN.
- Reset asserted in any state forces the reset values immediately, regardless of `Clk`.

## Timing
- The ROM read and the decode are combinational from `InstAddr`. Control inputs therefore describe the instruction at the current PC within the same cycle.
- PC update latency is 1 cycle. A taken jump's target appears on `InstAddr` the cycle after the jump instruction, with no bubble.
- A target-register write is visible to a jump in the very next cycle.
- `Running` and `Done` change on the clock edge that performs the state transition. `Done` rises the cycle after `Ack`.
- `Start` and `Ack` are sampled only on rising edges. A `Start` pulse longer than 1 cycle in IDLE/HALT triggers a single start.

## Structure
- Shared package holds:
  - the FSM state enum (`kIdle`, `kRun`, `kHalt`);
  - the `PCRegSelect` encoding constants;
  - the `PC_WIDTH` default.
- Optional sub-module `pc_target_regs`: three writable target registers plus the hardwired entry 0, with one write port and one combinational read port.
- FSM, PC register and counter stay in `pc_fetch`.

## Test plan
- Reset then `Start`: `InstAddr` steps 0,1,2,3 on successive cycles; `Running`=1; after 4 cycles `InstCount`=4.
- Target write: at PC=5 apply sel=10, `OffsetEn`=1, `ImmOut`=0x12 → `TgtReg[2]`=0x17 and PC goes to 6. Next cycle apply `JumpNotEqual`=1, `ZeroFlag`=0, sel=10 → `InstAddr`=0x17.
- Not-taken jump: `JumpEqual`=1, `ZeroFlag`=0 at PC=9 → PC=10. Taken jump with sel=00, `ZeroFlag`=1 → PC=`START_ADDR`.
- Wrap: with PC=0x3FF and no control → `InstAddr`=0x000. `Ack` asserted together with a taken jump → PC holds, `Done`=1 next cycle, `InstCount` unchanged.
- Restart from HALT: pulse `Start` → PC=0, `InstCount`=0, `TgtReg[2]` still 0x17.
- Drop `Reset` mid-RUN at PC=7 → outputs go to reset values immediately, before any clock edge.
